// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath width, bubble encoding,
// PC increment and the fetch-stage state type.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int PC_INCR = 4;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with load, hold and
// flush (bubble) controls. Flush has priority over load.
module if_id_reg #(
  parameter int XLEN = mips_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  // Neither load nor flush means the register holds (decode stalled).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: request/ready fetch from instruction memory, PC
// update, stall parking and branch/jump redirect with wrong-path discard.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int XLEN = mips_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_current,
  output logic            pc_write,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_valid
);

  localparam logic [XLEN-1:0] INCR = XLEN'(PC_INCR);

  fetch_state_t    state, next_state;
  logic            discard, next_discard;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc4;
  logic            capture_req;
  logic            park;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc4;
  logic            response;
  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_instr_d;
  logic [XLEN-1:0] ifid_pc4_d;

  // Once a request has waited a cycle, its address comes from req_addr so it
  // stays fixed even if the PC is redirected underneath it.
  assign fetch_pc  = (state == WAIT) ? req_addr : pc_current;
  assign fetch_pc4 = fetch_pc + INCR;
  assign imem_req  = (state != HOLD);
  assign imem_addr = fetch_pc;
  assign response  = imem_req & imem_ready;

  always_comb begin
    next_state   = state;
    next_discard = discard;
    capture_req  = 1'b0;
    park         = 1'b0;
    pc_write     = 1'b0;
    pc_next      = fetch_pc4;
    ifid_load    = 1'b0;
    ifid_instr_d = imem_rdata;
    ifid_pc4_d   = fetch_pc4;

    if (redirect_valid) begin
      pc_write = 1'b1;
      pc_next  = redirect_target;
      if (state == HOLD) begin
        next_state = ISSUE;
      end else if (response) begin
        next_discard = 1'b0;
        next_state   = ISSUE;
      end else begin
        // The outstanding request must still complete; mark it wrong-path.
        next_discard = 1'b1;
        next_state   = WAIT;
        capture_req  = (state == ISSUE);
      end
    end else if (response) begin
      if (discard) begin
        next_discard = 1'b0;
        next_state   = ISSUE;
      end else if (!stall) begin
        ifid_load  = 1'b1;
        pc_write   = 1'b1;
        next_state = ISSUE;
      end else begin
        park       = 1'b1;
        next_state = HOLD;
      end
    end else begin
      case (state)
        ISSUE: begin
          capture_req = 1'b1;
          next_state  = WAIT;
        end
        HOLD: begin
          if (!stall) begin
            ifid_load    = 1'b1;
            ifid_instr_d = hold_instr;
            ifid_pc4_d   = hold_pc4;
            pc_write     = 1'b1;
            pc_next      = hold_pc4;
            next_state   = ISSUE;
          end
        end
        default: next_state = state;
      endcase
    end
  end

  // A redirect always kills decode; otherwise an unstalled cycle without a
  // delivered instruction inserts a bubble.
  assign ifid_flush = redirect_valid | (~stall & ~ifid_load);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ISSUE;
      discard <= 1'b0;
    end else begin
      state   <= next_state;
      discard <= next_discard;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr   <= '0;
      hold_instr <= NOP_INSTR;
      hold_pc4   <= '0;
    end else begin
      if (capture_req) begin
        req_addr <= pc_current;
      end
      if (park) begin
        hold_instr <= imem_rdata;
        hold_pc4   <= fetch_pc4;
      end
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr_in    (ifid_instr_d),
    .pc_plus4_in (ifid_pc4_d),
    .instr       (if_id_instr),
    .pc_plus4    (if_id_pc_plus4),
    .valid       (if_id_valid)
  );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the pipelined MIPS core. It sits directly downstream of `program_counter`: it reads the current PC, issues a request/ready fetch to instruction memory, and loads the IF/ID pipeline register. It drives the PC's `write` and `nextIntruction` inputs and handles hazard-unit stalls and branch/jump redirects, including discarding an in-flight wrong-path fetch.

## Interface
Parameters:
- `XLEN`, 32: instruction and address width.
- `NOP_INSTR`, 32'h0000_0000: value loaded into IF/ID on reset and bubble (`sll $0,$0,0`).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc_current`  in  XLEN  `result` from `program_counter`.
- `pc_write`  out  1  to PC `write`.
- `pc_next`  out  XLEN  to PC `nextIntruction`.
- `imem_req`  out  1  fetch request; held until accepted.
- `imem_addr`  out  XLEN  fetch address; stable while `imem_req` is high.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  XLEN  fetched instruction.
- `stall`  in  1  hazard unit: hold IF/ID and the PC.
- `redirect_valid`  in  1  one-cycle pulse from EX: branch taken or jump.
- `redirect_target`  in  XLEN  new PC when `redirect_valid` is high.
- `if_id_instr`  out  XLEN  registered instruction to decode.
- `if_id_pc_plus4`  out  XLEN  registered PC+4 of that instruction.
- `if_id_valid`  out  1  registered: IF/ID holds a real instruction.

## Operation
- **States:**
  - ISSUE: `imem_req`=1, `imem_addr`=`pc_current`.
  - WAIT: `imem_req`=1, `imem_addr`=latched `req_addr`.
  - HOLD: `imem_req`=0; fetched word parked in `hold_instr`/`hold_pc4`.
- **Flags:** `discard` marks an outstanding fetch as wrong-path.
- **Reset values:** state=ISSUE, `discard`=0, `if_id_instr`=NOP_INSTR, `if_id_pc_plus4`=0, `if_id_valid`=0. Outputs `pc_write`, `imem_req`, `pc_next`, `imem_addr` are combinational from state and inputs and are not meaningful during reset.
- **Priority:** reset > redirect_valid > response arrival > stall.
- **Response** (`imem_req` & `imem_ready`):
  - `discard`=1 or `redirect_valid`=1: drop the word, clear `discard`, go to ISSUE.
  - Else `stall`=0: IF/ID <= {`imem_rdata`, `fetch_pc`+4, valid=1}; `pc_write`=1, `pc_next`=`fetch_pc`+4; go to ISSUE. `fetch_pc` is `pc_current` in ISSUE and `req_addr` in WAIT.
  - Else `stall`=1: park the word in the hold buffer; `pc_write`=0; go to HOLD.
- **ISSUE without ready:** `req_addr` <= `pc_current`; go to WAIT.
- **HOLD:** when `stall`=0, IF/ID <= hold buffer with valid=1, `pc_write`=1, `pc_next`=`hold_pc4`; go to ISSUE.
- **Redirect** (any state): `pc_write`=1, `pc_next`=`redirect_target`; IF/ID <= NOP with valid=0. This flushes the wrong-path instruction in decode.
  - In WAIT, or ISSUE without ready: set `discard`, stay in or enter WAIT.
  - In HOLD: drop the buffer and go to ISSUE.
- **Bubble:** `stall`=0, no redirect, and no instruction delivered this cycle: `if_id_valid` <= 0, `if_id_instr` <= NOP.
- **Stall hold:** `stall`=1 with no redirect: IF/ID registers hold their value.
- **Arithmetic:** PC+4 is modulo 2^XLEN; 32'hFFFF_FFFC+4 = 0. `redirect_target` is passed unchanged; alignment is not checked.

## Timing
- Zero-wait memory (`imem_ready` high in the request cycle): one instruction per cycle. Instruction at PC appears in IF/ID one edge after the fetch cycle. PC advances on the same edge.
- N wait cycles: fetch occupancy is N+1 cycles. `imem_addr` is held constant for all of them, even if a redirect arrives.
- Redirect → the first fetch of `redirect_target` issues the cycle after the PC updates. If a fetch is in flight, it issues the cycle after the discarded response.
- `pc_write` is never high during `stall`=1 unless `redirect_valid`=1.
- Asynchronous reset mid-WAIT abandons the request immediately. Memory must tolerate the `imem_req` drop.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum {ISSUE, WAIT, HOLD}.
  - `NOP_INSTR`.
  - `XLEN`.
  - `PC_INCR`=4.
- One natural sub-module: `if_id_reg`. It holds the IF/ID instr/pc_plus4/valid registers with load, hold and flush controls and asynchronous reset. The FSM, hold buffer and discard logic stay in `instruction_fetch`.

## Test plan
- Reset then zero-wait memory, PC=0: IF/ID shows words at 0, 4, 8 on consecutive cycles. `pc_write` is high every cycle. `if_id_valid` is 1 from the second edge.
- Memory with 2 wait cycles: `imem_addr` stays 0x10 for 3 cycles. PC advances to 0x14 only on the ready cycle. `if_id_valid` is 0 during the waits.
- `stall`=1 on the ready cycle for 3 cycles: word goes to HOLD, IF/ID and PC are frozen. On release, IF/ID gets the held word and PC = old+4.
- `redirect_valid` with target 0x400 during WAIT: PC=0x400 next edge and IF/ID valid=0. The late response for the old address is dropped. The next `imem_addr` is 0x400.
- Redirect together with `stall`=1 in HOLD: buffer dropped, PC=target, state ISSUE. IF/ID is flushed despite the stall.
- PC=0xFFFF_FFFC fetch: `pc_next`=0 and `if_id_pc_plus4`=0. Asserting `reset` mid-WAIT returns all registered outputs to reset values asynchronously.
